// File: rtl/sysid_boot_checker.sv
// Boot-time system ID checker: reads the ID and timestamp words from the sysid
// slave over Avalon-MM and keeps the CPU in reset until both match this build.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1355118694,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int          READ_LATENCY   = 0,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter int          RETRIES        = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata,
    output logic        cpu_reset_hold,
    output logic        done,
    output logic        id_ok,
    output logic        id_mismatch,
    output logic        timed_out,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ID   = 3'd1;
    localparam logic [2:0] WAIT_ID = 3'd2;
    localparam logic [2:0] RD_TS   = 3'd3;
    localparam logic [2:0] WAIT_TS = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;
    localparam logic [2:0] PASS    = 3'd6;
    localparam logic [2:0] FAIL    = 3'd7;

    localparam int          TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  L_LAST = 2'(READ_LATENCY - 1);
    localparam logic [2:0]  R_MAX  = 3'(RETRIES);

    logic [2:0]    state_r;
    logic [TW-1:0] tcnt_r;
    logic [1:0]    lat_r;
    logic [2:0]    retry_r;

    logic rd_phase_s;
    logic wait_phase_s;
    logic accept_s;
    logic capture_s;
    logic expire_s;
    logic word_ok_s;

    // Decode read handshake, data capture point, attempt expiry and word check.
    always_comb begin
        rd_phase_s   = (state_r == RD_ID) || (state_r == RD_TS);
        wait_phase_s = (state_r == WAIT_ID) || (state_r == WAIT_TS);
        accept_s     = rd_phase_s && !av_waitrequest;
        if (READ_LATENCY == 0) begin
            capture_s = accept_s;
        end else begin
            capture_s = wait_phase_s && (lat_r == L_LAST);
        end
        // capture in the final attempt cycle still counts; expiry only without it
        expire_s = (rd_phase_s || wait_phase_s) && (tcnt_r == T_LAST) && !capture_s;
        if (av_address) begin
            word_ok_s = !CHECK_TS || (av_readdata == EXPECTED_TS);
        end else begin
            word_ok_s = (av_readdata == EXPECTED_ID);
        end
    end

    // Sequencer and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            tcnt_r         <= '0;
            lat_r          <= 2'd0;
            retry_r        <= 3'd0;
            av_address     <= 1'b0;
            av_read        <= 1'b0;
            cpu_reset_hold <= 1'b1;
            done           <= 1'b0;
            id_ok          <= 1'b0;
            id_mismatch    <= 1'b0;
            timed_out      <= 1'b0;
            captured_id    <= 32'd0;
            captured_ts    <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r    <= RD_ID;
                    av_read    <= 1'b1;
                    av_address <= 1'b0;
                    tcnt_r     <= '0;
                    retry_r    <= 3'd0;
                end
                RD_ID, WAIT_ID, RD_TS, WAIT_TS: begin
                    if (capture_s) begin
                        if (av_address) begin
                            captured_ts <= av_readdata;
                        end else begin
                            captured_id <= av_readdata;
                        end
                        if (!word_ok_s) begin
                            state_r     <= FAIL;
                            av_read     <= 1'b0;
                            done        <= 1'b1;
                            id_mismatch <= 1'b1;
                        end else if (!av_address) begin
                            state_r    <= RD_TS;
                            av_read    <= 1'b1;
                            av_address <= 1'b1;
                            tcnt_r     <= '0;
                            retry_r    <= 3'd0;
                        end else begin
                            state_r        <= PASS;
                            av_read        <= 1'b0;
                            done           <= 1'b1;
                            id_ok          <= 1'b1;
                            cpu_reset_hold <= 1'b0;
                        end
                    end else if (expire_s) begin
                        av_read <= 1'b0;
                        tcnt_r  <= '0;
                        if (retry_r == R_MAX) begin
                            state_r   <= FAIL;
                            done      <= 1'b1;
                            timed_out <= 1'b1;
                        end else begin
                            state_r <= GAP;
                            retry_r <= retry_r + 3'd1;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                        if (accept_s) begin
                            state_r <= av_address ? WAIT_TS : WAIT_ID;
                            av_read <= 1'b0;
                            lat_r   <= 2'd0;
                        end else if (wait_phase_s) begin
                            lat_r <= lat_r + 2'd1;
                        end else begin
                            lat_r <= lat_r;
                        end
                    end
                end
                GAP: begin
                    state_r <= av_address ? RD_TS : RD_ID;
                    av_read <= 1'b1;
                    tcnt_r  <= '0;
                end
                PASS, FAIL: begin
                    if (start) begin
                        state_r        <= RD_ID;
                        av_read        <= 1'b1;
                        av_address     <= 1'b0;
                        tcnt_r         <= '0;
                        retry_r        <= 3'd0;
                        cpu_reset_hold <= 1'b1;
                        done           <= 1'b0;
                        id_ok          <= 1'b0;
                        id_mismatch    <= 1'b0;
                        timed_out      <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    av_read <= 1'b0;
                end
            endcase
        end
    end

endmodule
